// File: rtl/yupd_pkg.sv
// Shared types for the Y-bus delta update engine: complex entry, FSM states, op selectors.
package yupd_pkg;

  localparam int YUPD_CW = 24;

  typedef struct packed {
    logic signed [YUPD_CW-1:0] re;
    logic signed [YUPD_CW-1:0] im;
  } cplx_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    RD   = 3'd2,
    WT   = 3'd3,
    WR   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_RR = 2'd0,
    OP_CC = 2'd1,
    OP_RC = 2'd2,
    OP_CR = 2'd3
  } op_sel_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Diagonal ops accumulate the delta, off-diagonal ops remove it.
  function automatic logic op_dir(input op_sel_t op);
    return ((op == OP_RC) || (op == OP_CR)) ? OP_SUB : OP_ADD;
  endfunction

endpackage

// File: rtl/yupd_if.sv
// Change-record stream and Y SRAM port bundle for the delta update engine.
interface yupd_if #(
  parameter int CW    = 24,
  parameter int IDX_W = 16,
  parameter int AW    = 12
) ();
  logic              chg_valid;
  logic              chg_ready;
  logic [IDX_W-1:0]  chg_row;
  logic [IDX_W-1:0]  chg_col;
  logic [CW-1:0]     chg_real;
  logic [CW-1:0]     chg_img;
  logic              chg_last;
  logic              ymem_rd_en;
  logic [AW-1:0]     ymem_rd_addr;
  logic [2*CW-1:0]   ymem_rd_data;
  logic              ymem_wr_en;
  logic [AW-1:0]     ymem_wr_addr;
  logic [2*CW-1:0]   ymem_wr_data;

  modport master (
    output chg_valid, chg_row, chg_col, chg_real, chg_img, chg_last, ymem_rd_data,
    input  chg_ready, ymem_rd_en, ymem_rd_addr, ymem_wr_en, ymem_wr_addr, ymem_wr_data
  );

  modport slave (
    input  chg_valid, chg_row, chg_col, chg_real, chg_img, chg_last, ymem_rd_data,
    output chg_ready, ymem_rd_en, ymem_rd_addr, ymem_wr_en, ymem_wr_addr, ymem_wr_data
  );
endinterface

// File: rtl/yupd_fifo.sv
// Synchronous change-record FIFO with registered full/empty flags.
// DEPTH must be a power of two; push while full is accepted only together with a pop.
module yupd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push_s, do_pop_s;

  assign do_pop_s  = pop && !empty_q;
  assign do_push_s = push && (!full_q || do_pop_s);

  // Pointer, occupancy and storage next-state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (PW+1)'(DEPTH));
    empty_d = (count_d == (PW+1)'(0));
  end

  // FIFO state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= (PW+1)'(0);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/y_delta_update_unit.sv
// Y-bus delta update engine: queues change records and applies them to the Y SRAM by serialised RMW.
// Build option: define YUPD_SAT_EN to clamp overflowed components instead of wrapping.
module y_delta_update_unit
  import yupd_pkg::*;
#(
  parameter int CW         = 24,
  parameter int N_BUS      = 64,
  parameter int IDX_W      = 16,
  parameter int AW         = $clog2(N_BUS*N_BUS),
  parameter int FIFO_DEPTH = 8
) (
  input  logic  clock,
  input  logic  reset,
  yupd_if.slave bus,
  output logic  busy,
  output logic  done,
  output logic  err_idx,
  output logic  ovf
);
  localparam int RW = 2*IDX_W + 2*CW + 1;

  state_t            state_q, state_d;
  op_sel_t           op_q, op_d;
  logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
  logic [CW-1:0]     dre_q, dre_d, dim_q, dim_d;
  logic              last_q, last_d;
  logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [2*CW-1:0]   wr_data_q, wr_data_d;
  logic              done_q, done_d, err_q, err_d, ovf_q, ovf_d;

  logic [RW-1:0]     fifo_wdata_s, fifo_head_s;
  logic              fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic [IDX_W-1:0]  head_row_s, head_col_s;
  logic [CW-1:0]     head_re_s, head_im_s;
  logic              head_last_s, head_in_range_s, last_op_s;
  logic [CW:0]       sum_re_s, sum_im_s;
  logic              ovf_re_s, ovf_im_s;

  function automatic logic [AW-1:0] op_addr(input logic [IDX_W-1:0] r,
                                            input logic [IDX_W-1:0] c,
                                            input op_sel_t op);
    logic [IDX_W-1:0] a, b;
    case (op)
      OP_RR:   begin a = r; b = r; end
      OP_CC:   begin a = c; b = c; end
      OP_RC:   begin a = r; b = c; end
      OP_CR:   begin a = c; b = r; end
      default: begin a = r; b = r; end
    endcase
    return AW'(a * N_BUS + b);
  endfunction

  // One extra bit holds the exact result; top two bits differing means overflow.
  function automatic logic [CW:0] add_sub(input logic [CW-1:0] x, input logic [CW-1:0] d,
                                          input logic dir);
    logic [CW:0] xe, de;
    xe = {x[CW-1], x};
    de = {d[CW-1], d};
    return (dir == OP_SUB) ? (xe - de) : (xe + de);
  endfunction

  function automatic logic [CW-1:0] fit(input logic [CW:0] s);
`ifdef YUPD_SAT_EN
    if (s[CW] != s[CW-1]) begin
      return s[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
    end else begin
      return s[CW-1:0];
    end
`else
    return s[CW-1:0];
`endif
  endfunction

  assign push_s       = bus.chg_valid && !fifo_full_s;
  assign fifo_wdata_s = {bus.chg_row, bus.chg_col, bus.chg_real, bus.chg_img, bus.chg_last};

  yupd_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (fifo_wdata_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign {head_row_s, head_col_s, head_re_s, head_im_s, head_last_s} = fifo_head_s;
  assign head_in_range_s = (head_row_s < IDX_W'(N_BUS)) && (head_col_s < IDX_W'(N_BUS));
  assign last_op_s = (row_q == col_q) ? (op_q == OP_RR) : (op_q == OP_CR);

  // SRAM read data arrives during WT; the result is registered so it is driven in WR.
  assign sum_re_s = add_sub(bus.ymem_rd_data[2*CW-1:CW], dre_q, op_dir(op_q));
  assign sum_im_s = add_sub(bus.ymem_rd_data[CW-1:0],    dim_q, op_dir(op_q));
  assign ovf_re_s = sum_re_s[CW] ^ sum_re_s[CW-1];
  assign ovf_im_s = sum_im_s[CW] ^ sum_im_s[CW-1];

  // Sequencer next-state and registered strobes.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    row_d     = row_q;
    col_d     = col_q;
    dre_d     = dre_q;
    dim_d     = dim_q;
    last_d    = last_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    ovf_d     = ovf_q;
    pop_s     = 1'b0;
    done_d    = push_s ? 1'b0 : done_q;
    case (state_q)
      IDLE: state_d = fifo_empty_s ? IDLE : POP;
      POP: begin
        pop_s  = 1'b1;
        row_d  = head_row_s;
        col_d  = head_col_s;
        dre_d  = head_re_s;
        dim_d  = head_im_s;
        last_d = head_last_s;
        op_d   = OP_RR;
        if (head_in_range_s) begin
          state_d   = RD;
          rd_en_d   = 1'b1;
          rd_addr_d = op_addr(head_row_s, head_col_s, OP_RR);
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
          done_d  = head_last_s ? 1'b1 : done_d;
        end
      end
      RD: state_d = WT;
      WT: begin
        state_d   = WR;
        wr_en_d   = 1'b1;
        wr_addr_d = rd_addr_q;
        wr_data_d = {fit(sum_re_s), fit(sum_im_s)};
        ovf_d     = ovf_q | ovf_re_s | ovf_im_s;
      end
      WR: begin
        if (last_op_s) begin
          state_d = IDLE;
          done_d  = last_q ? 1'b1 : done_d;
        end else begin
          op_d      = op_sel_t'(op_q + 2'd1);
          state_d   = RD;
          rd_en_d   = 1'b1;
          rd_addr_d = op_addr(row_q, col_q, op_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Engine state and output registers; reset abandons any in-flight RMW.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= OP_RR;
      row_q     <= IDX_W'(0);
      col_q     <= IDX_W'(0);
      dre_q     <= CW'(0);
      dim_q     <= CW'(0);
      last_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= AW'(0);
      wr_en_q   <= 1'b0;
      wr_addr_q <= AW'(0);
      wr_data_q <= (2*CW)'(0);
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      row_q     <= row_d;
      col_q     <= col_d;
      dre_q     <= dre_d;
      dim_q     <= dim_d;
      last_q    <= last_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.chg_ready    = !fifo_full_s;
  assign bus.ymem_rd_en   = rd_en_q;
  assign bus.ymem_rd_addr = rd_addr_q;
  assign bus.ymem_wr_en   = wr_en_q;
  assign bus.ymem_wr_addr = wr_addr_q;
  assign bus.ymem_wr_data = wr_data_q;
  assign busy    = (state_q != IDLE) || !fifo_empty_s;
  assign done    = done_q;
  assign err_idx = err_q;
  assign ovf     = ovf_q;
endmodule
